// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: picks the hours/minutes source for the BCD/7-segment
// converter, runs the set-time/set-alarm mode machine, blinks the display
// while a value is being entered, and scans the four converter digits onto
// one segment bus with a one-hot digit enable.
module display_scan_ctrl #(
  parameter int SCAN_DIV   = 4,   // clk cycles each digit stays enabled
  parameter int BLINK_DIV  = 8,   // clk cycles per blink half-period
  parameter int ALARM_HOLD = 16   // clk cycles the alarm time is shown
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [3:0]  i_hours_time,
  input  logic [5:0]  i_mins_time,
  input  logic [3:0]  i_hours_alarm,
  input  logic [5:0]  i_mins_alarm,
  input  logic [3:0]  i_hours_key,
  input  logic [5:0]  i_mins_key,
  input  logic        i_show_alarm,
  input  logic        i_set_time_req,
  input  logic        i_set_alarm_req,
  input  logic        i_confirm,
  input  logic        i_cancel,
  input  logic [13:0] i_hours_disp,
  input  logic [13:0] i_mins_disp,
  output logic [3:0]  o_hours_cur,
  output logic [5:0]  o_mins_cur,
  output logic [6:0]  o_seg,
  output logic [3:0]  o_digit_en,
  output logic [1:0]  o_mode,
  output logic        o_load_new_time,
  output logic        o_load_new_alarm,
  output logic        o_entry_err
);

  localparam int SCAN_W  = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
  localparam int BLINK_W = (BLINK_DIV  > 1) ? $clog2(BLINK_DIV)  : 1;
  localparam int HOLD_W  = (ALARM_HOLD > 1) ? $clog2(ALARM_HOLD) : 1;

  // Encoding equals the mode output; bit 1 set means a SET state.
  typedef enum logic [1:0] {
    S_SHOW_TIME  = 2'b00,
    S_SHOW_ALARM = 2'b01,
    S_SET_TIME   = 2'b10,
    S_SET_ALARM  = 2'b11
  } state_t;

  state_t               r_state, w_state_next;
  logic [HOLD_W-1:0]    r_hold_cnt, w_hold_next;
  logic [BLINK_W-1:0]   r_blink_cnt, w_blink_next;
  logic                 r_blank, w_blank_next;   // 1 = blink phase off
  logic [SCAN_W-1:0]    r_scan_cnt;
  logic [1:0]           r_digit_idx;
  logic                 w_key_ok;
  logic                 w_load_time, w_load_alarm, w_err;
  logic [6:0]           w_digit_seg;
  logic [3:0]           w_src_hours;
  logic [5:0]           w_src_mins;

  assign w_key_ok = (i_hours_key <= 4'd12) && (i_mins_key <= 6'd59);

  // Next state, alarm-hold counter and commit/error pulses.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    w_state_next = r_state;
    w_hold_next  = r_hold_cnt;
    w_load_time  = 1'b0;
    w_load_alarm = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      S_SHOW_TIME, S_SHOW_ALARM: begin
        if (r_state == S_SHOW_ALARM) begin
          if (r_hold_cnt == HOLD_W'(ALARM_HOLD - 1)) begin
            w_state_next = S_SHOW_TIME;
            w_hold_next  = '0;
          end else begin
            w_hold_next = r_hold_cnt + 1'b1;
          end
        end
        // Only the set requests and show_alarm apply here; highest wins.
        if (i_set_alarm_req) begin
          w_state_next = S_SET_ALARM;
        end else if (i_set_time_req) begin
          w_state_next = S_SET_TIME;
        end else if (i_show_alarm) begin
          w_state_next = S_SHOW_ALARM;
          w_hold_next  = '0;
        end
      end
      S_SET_TIME, S_SET_ALARM: begin
        if (i_cancel) begin
          w_state_next = S_SHOW_TIME;
        end else if (i_confirm) begin
          if (w_key_ok) begin
            w_state_next = S_SHOW_TIME;
            w_load_time  = (r_state == S_SET_TIME);
            w_load_alarm = (r_state == S_SET_ALARM);
          end else begin
            w_err = 1'b1;
          end
        end
      end
    endcase
  end

  // Blink counter/phase: restart visible on SET entry, forced visible outside SET.
  always_comb begin
    w_blink_next = r_blink_cnt;
    w_blank_next = r_blank;
    if (!w_state_next[1] || !r_state[1]) begin
      w_blink_next = '0;
      w_blank_next = 1'b0;
    end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      w_blink_next = '0;
      w_blank_next = ~r_blank;
    end else begin
      w_blink_next = r_blink_cnt + 1'b1;
    end
  end

  // Source for the converter follows the state being entered, so the new
  // source appears together with the new mode.
  always_comb begin
    w_src_hours = i_hours_time;
    w_src_mins  = i_mins_time;
    case (w_state_next)
      S_SHOW_TIME:  begin w_src_hours = i_hours_time;  w_src_mins = i_mins_time;  end
      S_SHOW_ALARM: begin w_src_hours = i_hours_alarm; w_src_mins = i_mins_alarm; end
      S_SET_TIME,
      S_SET_ALARM:  begin w_src_hours = i_hours_key;   w_src_mins = i_mins_key;   end
    endcase
  end

  // Select the converter field for the digit currently being scanned.
  always_comb begin
    w_digit_seg = i_mins_disp[6:0];
    case (r_digit_idx)
      2'd0: w_digit_seg = i_mins_disp[6:0];
      2'd1: w_digit_seg = i_mins_disp[13:7];
      2'd2: w_digit_seg = i_hours_disp[6:0];
      2'd3: w_digit_seg = i_hours_disp[13:7];
    endcase
  end

  // Mode machine, counters and all registered outputs.
  always_ff @(posedge i_clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (i_reset) begin
      r_state          <= S_SHOW_TIME;
      r_hold_cnt       <= '0;
      r_blink_cnt      <= '0;
      r_blank          <= 1'b0;
      r_scan_cnt       <= '0;
      r_digit_idx      <= 2'd0;
      o_hours_cur      <= '0;
      o_mins_cur       <= '0;
      o_seg            <= '0;
      o_digit_en       <= '0;
      o_load_new_time  <= 1'b0;
      o_load_new_alarm <= 1'b0;
      o_entry_err      <= 1'b0;
    end else begin
      r_state          <= w_state_next;
      r_hold_cnt       <= w_hold_next;
      r_blink_cnt      <= w_blink_next;
      r_blank          <= w_blank_next;
      o_hours_cur      <= w_src_hours;
      o_mins_cur       <= w_src_mins;
      o_load_new_time  <= w_load_time;
      o_load_new_alarm <= w_load_alarm;
      o_entry_err      <= w_err;
      // Scan runs in every state and ignores mode changes.
      if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        r_scan_cnt  <= '0;
        r_digit_idx <= r_digit_idx + 2'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end
      // seg and digit_en share one stage so they never disagree; blanking
      // uses the phase of the cycle the outputs are shown in.
      o_seg      <= w_blank_next ? 7'd0 : w_digit_seg;
      o_digit_en <= w_blank_next ? 4'd0 : (4'b0001 << r_digit_idx);
    end
  end

  assign o_mode = r_state;

endmodule
